// File: rtl/ct_spsram_arb_ctrl_pkg.sv
// Shared constants for the single-port SRAM arbiter/controller: macro geometry
// and the two-state controller encoding.
package ct_spsram_arb_ctrl_pkg;
  localparam int SRAM_ADDR_W = 14;
  localparam int SRAM_DATA_W = 128;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// Two-way round-robin arbiter. ptr names the requester that wins a tie.
module ct_spsram_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);
endmodule

// File: rtl/ct_spsram_arb_ctrl.sv
// Single-port SRAM controller: zero-fills the macro after reset or on request,
// then arbitrates two requesters round-robin, one access per cycle.
module ct_spsram_arb_ctrl
  import ct_spsram_arb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  r0_req,
  input  logic                  r0_wr,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [DATA_WIDTH-1:0] r0_wmask,
  output logic                  r0_gnt,
  input  logic                  r1_req,
  input  logic                  r1_wr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [DATA_WIDTH-1:0] r1_wmask,
  output logic                  r1_gnt,
  output logic                  rd_vld,
  output logic                  rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  logic                  state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rr_ptr;
  logic [ADDR_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_d;

  logic                  arb_en;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  any_gnt;
  logic                  gid;
  logic                  g_wr;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [DATA_WIDTH-1:0] g_wmask;

  // An init request steals its own cycle: nobody is granted while it is seen.
  assign arb_en = (state == ST_RUN) && !init_req;
  assign req    = {r1_req, r0_req} & {2{arb_en}};

  ct_spsram_rr_arb2 u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign r0_gnt  = gnt[0];
  assign r1_gnt  = gnt[1];
  assign any_gnt = |gnt;
  assign gid     = gnt[1];
  assign g_wr    = gid ? r1_wr    : r0_wr;
  assign g_addr  = gid ? r1_addr  : r0_addr;
  assign g_wdata = gid ? r1_wdata : r0_wdata;
  assign g_wmask = gid ? r1_wmask : r0_wmask;

  assign init_done = (state == ST_RUN);
  assign rd_data   = sram_q;

  // Idle cycles park A/D on the last driven values to avoid needless toggling.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = hold_a;
    sram_d    = hold_d;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
      sram_d    = '0;
    end else if (any_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = ~g_wr;
      sram_wen  = g_wr ? ~g_wmask : '1;
      sram_a    = g_addr;
      sram_d    = g_wdata;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rr_ptr   <= 1'b0;
      rd_vld   <= 1'b0;
      rd_id    <= 1'b0;
      hold_a   <= '0;
      hold_d   <= '0;
    end else begin
      rd_vld <= any_gnt & ~g_wr;
      if (any_gnt & ~g_wr) rd_id  <= gid;
      if (any_gnt)         rr_ptr <= ~gid;
      if (!sram_cen) begin
        hold_a <= sram_a;
        hold_d <= sram_d;
      end
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (&init_cnt) state <= ST_RUN;
        end
        default: if (init_req) state <= ST_INIT;
      endcase
    end
  end
endmodule
